// File: rtl/usb_byte_receiver.sv
// USB full-speed receive front end: line sync, bit-timing recovery, NRZI decode,
// bit unstuffing, SYNC check and LSB-first byte assembly with EOP/error reporting.
//
// state      | meaning
// -----------+----------------------------------------------------------------
// S_IDLE     | line idle (J), waiting for the first J->K edge of a packet
// S_SYNC     | shifting the 8 SYNC bits, compared against SYNC_BYTE when done
// S_RECV     | receiving unstuffed data bits, one byte per 8 bits
// S_EOP_WAIT | one SE0 seen on a byte boundary, expecting SE0 then J
// S_ERR_WAIT | error seen; waiting for CLKS_PER_BIT consecutive J clocks
module usb_byte_receiver #(
  parameter int         CLKS_PER_BIT = 8,
  parameter int         SAMPLE_POINT = 3,
  parameter logic [7:0] SYNC_BYTE    = 8'h80
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_plus,
  input  logic       d_minus,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       rcving,
  output logic       eop_detected,
  output logic       rx_error,
  output logic       stuff_err
);

  localparam int            TW          = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] LAST_TICK   = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] SAMPLE_TICK = TW'(SAMPLE_POINT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_RECV,
    S_EOP_WAIT,
    S_ERR_WAIT
  } state_t;

  logic          r_dp_meta, r_dp_sync, r_dp_prev;
  logic          r_dm_meta, r_dm_sync;
  logic [TW-1:0] r_bit_timer;

  state_t        r_state;
  logic          r_prev_nrzi;
  logic [2:0]    r_ones_cnt;
  logic [2:0]    r_bit_cnt;
  logic [6:0]    r_shift;
  logic          r_se0_twice;
  logic [TW-1:0] r_j_cnt;
  logic [7:0]    r_rx_byte;
  logic          r_byte_valid;
  logic          r_rcving;
  logic          r_eop;
  logic          r_rx_error;
  logic          r_stuff_err;

  logic          w_dp_edge;
  logic          w_dp_fall;
  logic          w_strobe;
  logic          w_bit;
  logic          w_se0;
  logic          w_line_j;
  logic [7:0]    w_byte;

  // prev stage doubles as the edge detector for bit-timer realignment
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_dp_meta <= 1'b1;
      r_dp_sync <= 1'b1;
      r_dp_prev <= 1'b1;
      r_dm_meta <= 1'b0;
      r_dm_sync <= 1'b0;
    end else begin
      r_dp_meta <= d_plus;
      r_dp_sync <= r_dp_meta;
      r_dp_prev <= r_dp_sync;
      r_dm_meta <= d_minus;
      r_dm_sync <= r_dm_meta;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_bit_timer <= '0;
    end else if (w_dp_edge || (r_bit_timer == LAST_TICK)) begin
      r_bit_timer <= '0;
    end else begin
      r_bit_timer <= r_bit_timer + 1'b1;
    end
  end

  assign w_dp_edge = r_dp_sync ^ r_dp_prev;
  assign w_dp_fall = r_dp_prev & ~r_dp_sync;
  assign w_strobe  = (r_bit_timer == SAMPLE_TICK);
  assign w_bit     = (r_dp_sync == r_prev_nrzi);
  assign w_se0     = ~r_dp_sync & ~r_dm_sync;
  assign w_line_j  = r_dp_sync & ~r_dm_sync;
  assign w_byte    = {w_bit, r_shift};

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state      <= S_IDLE;
      r_prev_nrzi  <= 1'b1;
      r_ones_cnt   <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_se0_twice  <= 1'b0;
      r_j_cnt      <= LAST_TICK;
      r_rx_byte    <= '0;
      r_byte_valid <= 1'b0;
      r_rcving     <= 1'b0;
      r_eop        <= 1'b0;
      r_rx_error   <= 1'b0;
      r_stuff_err  <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      r_eop        <= 1'b0;
      r_stuff_err  <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_dp_fall) begin
            r_state     <= S_SYNC;
            r_rx_error  <= 1'b0;
            r_ones_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_prev_nrzi <= 1'b1;
            r_rcving    <= 1'b1;
          end
        end

        S_SYNC: begin
          if (w_strobe) begin
            r_prev_nrzi <= r_dp_sync;
            r_shift     <= w_byte[7:1];
            if (r_bit_cnt == 3'd7) begin
              r_bit_cnt <= '0;
              if (w_byte == SYNC_BYTE) begin
                r_state <= S_RECV;
              end else begin
                r_rx_error <= 1'b1;
                r_rcving   <= 1'b0;
                r_j_cnt    <= LAST_TICK;
                r_state    <= S_ERR_WAIT;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end
        end

        S_RECV: begin
          if (w_strobe) begin
            r_prev_nrzi <= r_dp_sync;
            if (w_se0) begin
              if (r_bit_cnt == 3'd0) begin
                r_se0_twice <= 1'b0;
                r_state     <= S_EOP_WAIT;
              end else begin
                r_rx_error <= 1'b1;
                r_rcving   <= 1'b0;
                r_j_cnt    <= LAST_TICK;
                r_state    <= S_ERR_WAIT;
              end
            end else if (r_ones_cnt == 3'd6) begin
              // this slot carries the stuff bit, never data
              if (w_bit) begin
                r_stuff_err <= 1'b1;
                r_rx_error  <= 1'b1;
                r_rcving    <= 1'b0;
                r_j_cnt     <= LAST_TICK;
                r_state     <= S_ERR_WAIT;
              end else begin
                r_ones_cnt <= '0;
              end
            end else begin
              r_shift    <= w_byte[7:1];
              r_ones_cnt <= w_bit ? (r_ones_cnt + 3'd1) : 3'd0;
              if (r_bit_cnt == 3'd7) begin
                r_bit_cnt    <= '0;
                r_rx_byte    <= w_byte;
                r_byte_valid <= 1'b1;
              end else begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
              end
            end
          end
        end

        S_EOP_WAIT: begin
          if (w_strobe) begin
            if (w_se0) begin
              r_se0_twice <= 1'b1;
            end else if (w_line_j && r_se0_twice) begin
              r_eop    <= 1'b1;
              r_rcving <= 1'b0;
              r_state  <= S_IDLE;
            end else begin
              r_rx_error <= 1'b1;
              r_rcving   <= 1'b0;
              r_j_cnt    <= LAST_TICK;
              r_state    <= S_ERR_WAIT;
            end
          end
        end

        S_ERR_WAIT: begin
          r_rcving <= 1'b0;
          if (w_line_j) begin
            if (r_j_cnt == '0) begin
              r_state <= S_IDLE;
            end else begin
              r_j_cnt <= r_j_cnt - 1'b1;
            end
          end else begin
            r_j_cnt <= LAST_TICK;
          end
        end

        default: begin
          r_state  <= S_IDLE;
          r_rcving <= 1'b0;
        end
      endcase
    end
  end

  assign rx_byte      = r_rx_byte;
  assign byte_valid   = r_byte_valid;
  assign rcving       = r_rcving;
  assign eop_detected = r_eop;
  assign rx_error     = r_rx_error;
  assign stuff_err    = r_stuff_err;

endmodule

// File: tb/tb_usb_byte_receiver.sv
// Directed bench for usb_byte_receiver: an NRZI/stuffing line driver feeds packets,
// expected pulses go into a scoreboard queue that a negedge monitor drains.
module tb_usb_byte_receiver;

  localparam int CLKS = 8;
  localparam int K_BYTE  = 0;
  localparam int K_EOP   = 1;
  localparam int K_STUFF = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } exp_t;

  logic       clk;
  logic       n_rst;
  logic       d_plus;
  logic       d_minus;
  logic [7:0] rx_byte;
  logic       byte_valid;
  logic       rcving;
  logic       eop_detected;
  logic       rx_error;
  logic       stuff_err;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  logic level;
  int   tb_ones;

  usb_byte_receiver #(
    .CLKS_PER_BIT(8),
    .SAMPLE_POINT(3),
    .SYNC_BYTE   (8'h80)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .d_plus      (d_plus),
    .d_minus     (d_minus),
    .rx_byte     (rx_byte),
    .byte_valid  (byte_valid),
    .rcving      (rcving),
    .eop_detected(eop_detected),
    .rx_error    (rx_error),
    .stuff_err   (stuff_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %h, want %h", name, actual, expected);
    end
  endtask

  task automatic expect_evt(input int kind, input logic [7:0] data);
    exp_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic monitor_evt(input int kind, input logic [7:0] data);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event: got kind=%0d data=%h, want no event", kind, data);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || (kind == K_BYTE && e.data !== data)) begin
        failures++;
        $display("FAIL event_match: got kind=%0d data=%h, want kind=%0d data=%h",
                 kind, data, e.kind, e.data);
      end
    end
  endtask

  always @(negedge clk) begin
    if (n_rst) begin
      if (byte_valid) monitor_evt(K_BYTE, rx_byte);
      if (eop_detected) begin
        monitor_evt(K_EOP, 8'h00);
        check_eq("rcving_low_with_eop", {7'd0, rcving}, 8'd0);
      end
      if (stuff_err) monitor_evt(K_STUFF, 8'h00);
    end
  end

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s: got %0d events pending, want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // every line change lands 1 time unit after a rising edge and holds one bit time
  task automatic drive(input logic dp, input logic dm);
    d_plus  = dp;
    d_minus = dm;
    repeat (CLKS) @(posedge clk);
    #1;
  endtask

  task automatic send_raw(input logic b);
    if (!b) level = ~level;
    drive(level, ~level);
  endtask

  task automatic send_sync();
    logic [7:0] s;
    s = 8'h80;
    tb_ones = 0;
    for (int i = 0; i < 8; i++) send_raw(s[i]);
  endtask

  task automatic send_data(input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      send_raw(b[i]);
      tb_ones = b[i] ? tb_ones + 1 : 0;
      if (tb_ones == 6) begin
        send_raw(1'b0);
        tb_ones = 0;
      end
    end
  endtask

  task automatic send_eop();
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    level = 1'b1;
    drive(1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    level   = 1'b1;
    d_plus  = 1'b1;
    d_minus = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag, input logic exp_rcv, input logic exp_err);
    check_eq({tag, "_rcving"}, {7'd0, rcving}, {7'd0, exp_rcv});
    check_eq({tag, "_rx_error"}, {7'd0, rx_error}, {7'd0, exp_err});
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_rx_byte"}, rx_byte, 8'h00);
    check_eq({tag, "_byte_valid"}, {7'd0, byte_valid}, 8'd0);
    check_eq({tag, "_rcving"}, {7'd0, rcving}, 8'd0);
    check_eq({tag, "_eop"}, {7'd0, eop_detected}, 8'd0);
    check_eq({tag, "_rx_error"}, {7'd0, rx_error}, 8'd0);
    check_eq({tag, "_stuff_err"}, {7'd0, stuff_err}, 8'd0);
  endtask

  initial begin
    n_rst   = 1'b0;
    d_plus  = 1'b1;
    d_minus = 1'b0;
    level   = 1'b1;
    tb_ones = 0;
    repeat (4) @(posedge clk);
    #1;
    check_all_zero("reset");
    n_rst = 1'b1;
    idle(16);

    // clean packet with one data byte
    expect_evt(K_BYTE, 8'hA5);
    expect_evt(K_EOP, 8'h00);
    send_sync();
    check_status("a5_after_sync", 1'b1, 1'b0);
    send_data(8'hA5);
    send_eop();
    idle(16);
    check_status("a5_done", 1'b0, 1'b0);
    check_drained("a5_drained");

    // 0xFF needs a stuff bit after its sixth one
    expect_evt(K_BYTE, 8'hFF);
    expect_evt(K_BYTE, 8'h00);
    expect_evt(K_EOP, 8'h00);
    send_sync();
    send_data(8'hFF);
    send_data(8'h00);
    send_eop();
    idle(16);
    check_status("stuffed_done", 1'b0, 1'b0);
    check_drained("stuffed_drained");

    // seven ones without a stuff bit
    expect_evt(K_STUFF, 8'h00);
    send_sync();
    for (int i = 0; i < 7; i++) send_raw(1'b1);
    check_status("stuff_err", 1'b0, 1'b1);
    idle(16);
    check_drained("stuff_err_drained");
    check_status("stuff_err_idle", 1'b0, 1'b1);

    // recovery packet proves the receiver went back to idle
    expect_evt(K_BYTE, 8'h5A);
    expect_evt(K_EOP, 8'h00);
    send_sync();
    check_status("recover_after_sync", 1'b1, 1'b0);
    send_data(8'h5A);
    send_eop();
    idle(16);
    check_status("recover_done", 1'b0, 1'b0);
    check_drained("recover_drained");

    // corrupted sync byte 0x81
    begin
      logic [7:0] bad;
      bad = 8'h81;
      for (int i = 0; i < 8; i++) send_raw(bad[i]);
    end
    idle(12);
    check_status("bad_sync", 1'b0, 1'b1);
    idle(8);
    check_drained("bad_sync_drained");

    // SE0 after four data bits
    send_sync();
    send_raw(1'b1);
    send_raw(1'b0);
    send_raw(1'b1);
    send_raw(1'b0);
    drive(1'b0, 1'b0);
    check_status("partial_se0", 1'b0, 1'b1);
    drive(1'b0, 1'b0);
    idle(16);
    check_status("partial_idle", 1'b0, 1'b1);
    check_drained("partial_drained");

    // reset in the middle of a byte
    send_sync();
    send_raw(1'b0);
    send_raw(1'b0);
    send_raw(1'b1);
    repeat (3) @(posedge clk);
    #1;
    check_status("pre_reset", 1'b1, 1'b0);
    check_eq("pre_reset_rx_byte", rx_byte, 8'h5A);
    n_rst = 1'b0;
    #1;
    check_all_zero("mid_reset");
    level   = 1'b1;
    d_plus  = 1'b1;
    d_minus = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_rst = 1'b1;
    idle(16);
    check_drained("reset_drained");

    expect_evt(K_BYTE, 8'h3C);
    expect_evt(K_EOP, 8'h00);
    send_sync();
    check_status("post_reset_sync", 1'b1, 1'b0);
    send_data(8'h3C);
    send_eop();
    idle(16);
    check_eq("post_reset_rx_byte", rx_byte, 8'h3C);
    check_status("post_reset_done", 1'b0, 1'b0);
    check_drained("post_reset_drained");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/usb_byte_receiver.md
Name: usb_byte_receiver

Overview:
Receive-side counterpart of the USB full-speed byte transmitter. It takes raw d_plus/d_minus from the line and synchronizes them to the 96 MHz core clock. It recovers bit timing at 8 clocks per bit, performs NRZI decoding, removes stuffed bits, checks the SYNC pattern, and assembles LSB-first bytes. It reports end-of-packet and error status to the downstream receive FSM/FIFO.

Parameters:
CLKS_PER_BIT, 8, core clocks per USB bit (96 MHz / 12 Mbps)
SAMPLE_POINT, 3, bit-timer value at which the line is sampled (mid-bit)
SYNC_BYTE, 8'h80, expected first decoded byte (bits 0,0,0,0,0,0,0,1 on the wire, LSB first)

Ports:
clk  in  1  core clock, 96 MHz
n_rst  in  1  asynchronous active-low reset
d_plus  in  1  raw USB D+ (asynchronous to clk)
d_minus  in  1  raw USB D- (asynchronous to clk)
rx_byte  out  8  last completed data byte, LSB = first bit received
byte_valid  out  1  one-cycle pulse; rx_byte is new
rcving  out  1  high from detected SYNC start through EOP or error
eop_detected  out  1  one-cycle pulse on valid EOP
rx_error  out  1  sticky error flag; cleared at the next packet start
stuff_err  out  1  one-cycle pulse on a bit-stuffing violation

Behaviour:
- Reset values: rx_byte=0, byte_valid=0, rcving=0, eop_detected=0, rx_error=0, stuff_err=0. Internal: state=IDLE, prev_nrzi=1 (J), ones_cnt=0, bit_timer=0.
- Input sync: 2-FF synchronizer on each of d_plus and d_minus, reset to d_plus=1, d_minus=0 (J). All logic below uses the synchronized values.
- Bit timer: counts 0..CLKS_PER_BIT-1 and wraps. It resets to 0 on any transition of synced d_plus, which keeps it aligned to the transmitter's edges. sample_strobe fires when bit_timer==SAMPLE_POINT.
- NRZI decode at sample_strobe: bit = (d_plus == prev_nrzi) ? 1 : 0. Then prev_nrzi <= d_plus.
- Unstuff: ones_cnt increments on each decoded 1 and clears on 0. When ones_cnt==6, the next sampled bit is a stuff bit.
  - If that bit is 0: discard it, ones_cnt=0.
  - If that bit is 1: stuff_err pulse, rx_error=1, go to ERR_WAIT.
- SE0 = (d_plus==0 && d_minus==0) at sample_strobe.
- FSM states: IDLE, SYNC, RECV, EOP_WAIT, ERR_WAIT.
  - IDLE: on the first synced d_plus falling edge (J->K), clear rx_error, ones_cnt, bit counter and shift register; set rcving=1; go to SYNC.
  - SYNC: shift 8 bits. If the byte equals SYNC_BYTE, go to RECV. Otherwise set rx_error=1 and go to ERR_WAIT. The SYNC byte is never output.
  - RECV: shift unstuffed bits LSB-first into bit 7 of the shift register. After the 8th bit, rx_byte <= shifted byte and byte_valid pulses the clock after that sample_strobe.
    - SE0 sampled with bit count 0: go to EOP_WAIT.
    - SE0 sampled with bit count 1..7 (partial byte): rx_error=1, go to ERR_WAIT; the partial byte is discarded.
  - EOP_WAIT: needs a second SE0 sample, then a J sample (d_plus=1, d_minus=0). On J: eop_detected pulses, rcving=0, go to IDLE.
    - A J after only one SE0, or a K: rx_error=1, go to ERR_WAIT.
  - ERR_WAIT: rcving=0. Stay until the line has been J for CLKS_PER_BIT consecutive clocks, then go to IDLE. rx_error stays set.
- Simultaneous events: SE0 takes priority over stuff checking. A byte completion and a stuff error on the same strobe are impossible, because the stuff bit is not a data bit.
- Reset mid-packet: all outputs return to reset values immediately; no byte_valid or eop pulse is emitted.
- Latency: wire bit at mid-sample to byte_valid is 1 clock after the sample_strobe of the last data bit.

Test Plan:
- Bitstream SYNC, 0xA5, SE0 SE0 J at 8 clk/bit → one byte_valid with rx_byte=0xA5, then eop_detected one pulse; rx_error=0, rcving falls with eop.
- SYNC, 0xFF, 0x00 with transmitter-style stuff bit after the 6th one → byte_valid twice: 0xFF then 0x00; stuff_err never asserts.
- SYNC followed by seven consecutive decoded 1s → stuff_err pulse, rx_error=1, no byte_valid; returns to IDLE after 8 J clocks.
- Corrupted sync 0x81 → rx_error=1, no byte_valid, rcving=0 within one bit time.
- SE0 after 4 bits of a data byte → rx_error=1, no byte_valid for the partial byte, no eop_detected.
- Assert n_rst mid-byte → all outputs 0 on the same cycle. A following clean SYNC, 0x3C, EOP packet → rx_byte=0x3C, rx_error=0.
